program_sequencer_stack: RTL and testbench

Parametrised program sequencer for the microcontroller core. It generates the program-memory address each cycle, registers it as `pc`, and supports unconditional and conditional jumps. It adds what earlier sequencers lacked: subroutine call/return through a hardware return-address stack, a pipeline hold, and sticky stack error flags. It sits between the instruction decoder, which supplies the control strobes, and program memory, which consumes `pm_addr`.

---
 rtl/program_sequencer_stack_if.sv | 33 +++
 rtl/program_sequencer_stack.sv | 121 ++++++++++++
 tb/tb_program_sequencer_stack.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_stack_if.sv
// Control strobes from the instruction decoder and the address/stack view
// returned by the program sequencer.
interface program_sequencer_stack_if #(
    parameter int ADDR_W      = 8,
    parameter int JADDR_W     = 4,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic               jmp;
    logic               jmp_nz;
    logic               dont_jmp;
    logic               call;
    logic               ret;
    logic               hold;
    logic [JADDR_W-1:0] jmp_addr;
    logic [ADDR_W-1:0]  pm_addr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  from_PS;
    logic [SP_W-1:0]    stack_ptr;
    logic               stack_overflow;
    logic               stack_underflow;

    modport master (
        output jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
        input  pm_addr, pc, from_PS, stack_ptr, stack_overflow, stack_underflow
    );

    modport slave (
        input  jmp, jmp_nz, dont_jmp, call, ret, hold, jmp_addr,
        output pm_addr, pc, from_PS, stack_ptr, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program sequencer: next-address selection, registered pc, hardware
// return-address stack for call/ret, and sticky stack error flags.
module program_sequencer_stack #(
    parameter int ADDR_W      = 8,
    parameter int JADDR_W     = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic                       clk,
    input logic                       sync_reset,
    program_sequencer_stack_if.slave  bus
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_plus1_s;
    logic [ADDR_W-1:0] target_s;
    logic [ADDR_W-1:0] tos_s;
    logic [ADDR_W-1:0] pm_addr_s;
    logic              stack_empty_s;
    logic              stack_full_s;
    logic              push_s;
    logic              pop_s;

    assign pc_plus1_s    = pc_q + ADDR_W'(1);
    assign target_s      = ADDR_W'(bus.jmp_addr) << (ADDR_W - JADDR_W);
    assign stack_empty_s = (sp_q == SP_W'(0));
    assign stack_full_s  = (sp_q == SP_W'(STACK_DEPTH));

    // Top-of-stack read; zero when no entry is valid.
    always_comb begin
        tos_s = ADDR_W'(0);
        for (int i = 0; i < STACK_DEPTH; i++) begin
            tos_s = (sp_q == SP_W'(i + 1)) ? stack_q[i] : tos_s;
        end
    end

    // Priority decode of the strobes into next address and stack action.
    always_comb begin
        pm_addr_s = pc_plus1_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (sync_reset) begin
            pm_addr_s = ADDR_W'(0);
        end else if (bus.hold) begin
            pm_addr_s = pc_q;
        end else if (bus.ret) begin
            if (stack_empty_s) begin
                pm_addr_s = pc_plus1_s;
                unf_d     = 1'b1;
            end else begin
                pm_addr_s = tos_s;
                pop_s     = 1'b1;
            end
        end else if (bus.call) begin
            // An overflowing call still jumps; only the push is dropped.
            pm_addr_s = target_s;
            if (stack_full_s) begin
                ovf_d = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else if (bus.jmp) begin
            pm_addr_s = target_s;
        end else if (bus.jmp_nz && !bus.dont_jmp) begin
            pm_addr_s = target_s;
        end else begin
            pm_addr_s = pc_plus1_s;
        end
    end

    // Stack pointer next state.
    always_comb begin
        if (push_s) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop_s) begin
            sp_d = sp_q - SP_W'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Program counter, stack pointer and sticky flags.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc_q  <= ADDR_W'(0);
            sp_q  <= SP_W'(0);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pm_addr_s;
            sp_q  <= sp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_s && (sp_q == SP_W'(i))) begin
                stack_q[i] <= pc_plus1_s;
            end else begin
                stack_q[i] <= stack_q[i];
            end
        end
    end

    assign bus.pm_addr         = pm_addr_s;
    assign bus.pc              = pc_q;
    assign bus.from_PS         = tos_s;
    assign bus.stack_ptr       = sp_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer_stack.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based model.
module tb_program_sequencer_stack;
    localparam int ADDR_W = 8;
    localparam int JADDR_W = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic sync_reset;
    int   tests;
    int   fails;

    // Reference model state.
    int   m_pc;
    int   m_stk[$];
    bit   m_ovf;
    bit   m_unf;

    program_sequencer_stack_if #(.ADDR_W(ADDR_W), .JADDR_W(JADDR_W), .STACK_DEPTH(DEPTH)) bus ();

    program_sequencer_stack #(.ADDR_W(ADDR_W), .JADDR_W(JADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pm();
        int t;
        int nxt;
        t   = int'(bus.jmp_addr) * (1 << (ADDR_W - JADDR_W));
        nxt = (m_pc + 1) % (1 << ADDR_W);
        if (sync_reset) return 0;
        if (bus.hold) return m_pc;
        if (bus.ret) return (m_stk.size() > 0) ? m_stk[$] : nxt;
        if (bus.call || bus.jmp) return t;
        if (bus.jmp_nz && !bus.dont_jmp) return t;
        return nxt;
    endfunction

    task automatic model_update(input int pm);
        if (sync_reset) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (!bus.hold && bus.ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_unf = 1'b1;
            end else if (!bus.hold && bus.call) begin
                if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % (1 << ADDR_W));
                else m_ovf = 1'b1;
            end
            m_pc = pm;
        end
    endtask

    // One clock cycle: compare all outputs against the model mid-cycle.
    task automatic cycle();
        int exp_pm;
        exp_pm = model_pm();
        @(negedge clk);
        check("pm_addr", int'(bus.pm_addr), exp_pm);
        check("pc", int'(bus.pc), m_pc);
        check("from_PS", int'(bus.from_PS), (m_stk.size() > 0) ? m_stk[$] : 0);
        check("stack_ptr", int'(bus.stack_ptr), m_stk.size());
        check("overflow", int'(bus.stack_overflow), int'(m_ovf));
        check("underflow", int'(bus.stack_underflow), int'(m_unf));
        model_update(exp_pm);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit h, input bit rt, input bit c,
                         input bit j, input bit jn, input bit dj, input int a);
        sync_reset   = r;
        bus.hold     = h;
        bus.ret      = rt;
        bus.call     = c;
        bus.jmp      = j;
        bus.jmp_nz   = jn;
        bus.dont_jmp = dj;
        bus.jmp_addr = JADDR_W'(a);
        cycle();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic goto_addr(input int a);
        drive(0, 0, 0, 0, 1, 0, 0, a / 16);
        repeat (a % 16) idle();
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        bus.hold = 1'b0; bus.ret = 1'b0; bus.call = 1'b0; bus.jmp = 1'b0;
        bus.jmp_nz = 1'b0; bus.dont_jmp = 1'b0; bus.jmp_addr = '0;
        sync_reset = 1'b1;
        @(posedge clk);
        #1;
        m_pc = 0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;

        // Reset held with jmp asserted, then free-run.
        drive(1, 0, 0, 0, 1, 0, 0, 4'hA);
        drive(1, 0, 0, 0, 1, 0, 0, 4'hA);
        check("rst_pc", int'(bus.pc), 0);
        check("rst_sp", int'(bus.stack_ptr), 0);
        check("rst_from_PS", int'(bus.from_PS), 0);
        idle(); check("run_pc1", int'(bus.pc), 1);
        idle(); check("run_pc2", int'(bus.pc), 2);
        idle(); check("run_pc3", int'(bus.pc), 3);

        // Jumps and wrap.
        goto_addr('h05); check("at_05", int'(bus.pc), 'h05);
        drive(0, 0, 0, 0, 1, 0, 0, 4'hA); check("jmp_A0", int'(bus.pc), 'hA0);
        goto_addr('h10);
        drive(0, 0, 0, 0, 0, 1, 1, 4'h3); check("jnz_not_taken", int'(bus.pc), 'h11);
        goto_addr('h10);
        drive(0, 0, 0, 0, 0, 1, 0, 4'h3); check("jnz_taken", int'(bus.pc), 'h30);
        goto_addr('hFE);
        idle(); check("wrap_FF", int'(bus.pc), 'hFF);
        idle(); check("wrap_00", int'(bus.pc), 'h00);

        // Call and return.
        goto_addr('h07);
        drive(0, 0, 0, 1, 0, 0, 0, 4'h4);
        check("call_pc", int'(bus.pc), 'h40);
        check("call_sp", int'(bus.stack_ptr), 1);
        check("call_tos", int'(bus.from_PS), 'h08);
        idle(); idle();
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        check("ret_pc", int'(bus.pc), 'h08);
        check("ret_sp", int'(bus.stack_ptr), 0);

        // Nesting and overflow.
        do_reset(); idle();
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 1, 0, 0, 0, k);
            if (k < 5) idle();
        end
        check("ovf_sp", int'(bus.stack_ptr), 4);
        check("ovf_flag", int'(bus.stack_overflow), 1);
        check("ovf_pc", int'(bus.pc), 'h50);
        for (int k = 3; k >= 0; k--) begin
            drive(0, 0, 1, 0, 0, 0, 0, 0);
            check("nest_ret", int'(bus.pc), k * 16 + 2);
        end

        // Underflow is sticky until reset.
        do_reset();
        goto_addr('h20);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        check("unf_pc", int'(bus.pc), 'h21);
        check("unf_flag", int'(bus.stack_underflow), 1);
        idle(); idle();
        check("unf_sticky", int'(bus.stack_underflow), 1);
        do_reset();
        check("unf_cleared", int'(bus.stack_underflow), 0);

        // Hold and priority.
        goto_addr('h33);
        drive(0, 1, 0, 1, 0, 0, 0, 4'h4);
        check("hold_pc", int'(bus.pc), 'h33);
        check("hold_sp", int'(bus.stack_ptr), 0);
        goto_addr('h07);
        drive(0, 0, 0, 1, 0, 0, 0, 4'h4);
        drive(0, 0, 1, 1, 0, 0, 0, 4'h9);
        check("callret_pc", int'(bus.pc), 'h08);
        check("callret_sp", int'(bus.stack_ptr), 0);

        // Randomized run against the model.
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 25,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 1) == 1,  int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
